pcie_rx_class_router: RTL and testbench

//  Parametrised per-port RX traffic router for PCIe SS AXI-S. Takes RX-A and RX-B and

---
 rtl/pcie_rx_class_router.sv | 243 ++++++++++++++++++++++++
 tb/tb_pcie_rx_class_router.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_rx_class_router.sv
// Per-port RX router: splits whole AXI-S packets from RX-A/RX-B into four class FIFOs
// (mmio, cpl, commit, msg), counts routed packets and drops traffic on an illegal input.

module pcie_rx_class_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_V = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [PTR_W:0]   used;
  logic             rd_en;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign used     = wr_ptr - rd_ptr;
  assign full     = (used == DEPTH_V);
  assign rd_valid = (used != '0);
  assign rd_en    = rd_valid && rd_ready;
  assign rd_data  = mem[rd_ptr[PTR_W-1:0]];

  // NOTE: storage is not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[PTR_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

module pcie_rx_class_router #(
  parameter int TDATA_W     = 512,
  parameter int TUSER_W     = 10,
  parameter int CPL_ON_B    = 0,
  parameter int COMMIT_ON_B = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic                 rx_a_tvalid,
  input  logic                 rx_a_tlast,
  input  logic [TDATA_W-1:0]   rx_a_tdata,
  input  logic [TDATA_W/8-1:0] rx_a_tkeep,
  input  logic [TUSER_W-1:0]   rx_a_tuser_vendor,
  output logic                 rx_a_tready,

  input  logic                 rx_b_tvalid,
  input  logic                 rx_b_tlast,
  input  logic [TDATA_W-1:0]   rx_b_tdata,
  input  logic [TDATA_W/8-1:0] rx_b_tkeep,
  input  logic [TUSER_W-1:0]   rx_b_tuser_vendor,
  output logic                 rx_b_tready,

  output logic                 mmio_tvalid,
  output logic                 mmio_tlast,
  output logic [TDATA_W-1:0]   mmio_tdata,
  output logic [TDATA_W/8-1:0] mmio_tkeep,
  output logic [TUSER_W-1:0]   mmio_tuser_vendor,
  input  logic                 mmio_tready,

  output logic                 cpl_tvalid,
  output logic                 cpl_tlast,
  output logic [TDATA_W-1:0]   cpl_tdata,
  output logic [TDATA_W/8-1:0] cpl_tkeep,
  output logic [TUSER_W-1:0]   cpl_tuser_vendor,
  input  logic                 cpl_tready,

  output logic                 commit_tvalid,
  output logic                 commit_tlast,
  output logic [TDATA_W-1:0]   commit_tdata,
  output logic [TDATA_W/8-1:0] commit_tkeep,
  output logic [TUSER_W-1:0]   commit_tuser_vendor,
  input  logic                 commit_tready,

  output logic                 msg_tvalid,
  output logic                 msg_tlast,
  output logic [TDATA_W-1:0]   msg_tdata,
  output logic [TDATA_W/8-1:0] msg_tkeep,
  output logic [TUSER_W-1:0]   msg_tuser_vendor,
  input  logic                 msg_tready,

  output logic [4*CNT_W-1:0]   pkt_cnt,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic                 err_misroute
);

  localparam int KEEP_W = TDATA_W / 8;
  localparam int ENT_W  = 1 + TUSER_W + TDATA_W + KEEP_W;
  localparam int NCLS   = 4;

  typedef enum logic [1:0] {
    CLS_MMIO   = 2'd0,
    CLS_CPL    = 2'd1,
    CLS_COMMIT = 2'd2,
    CLS_MSG    = 2'd3
  } cls_e;

  // Bit per class: 1 when that class is legal only on RX-B, 0 when only on RX-A.
  localparam logic [NCLS-1:0] ON_B = {1'b0, (COMMIT_ON_B != 0), (CPL_ON_B != 0), 1'b0};

  function automatic cls_e classify(input logic [7:0] ft);
    if (ft[4:0] == 5'b01010) return ft[6] ? CLS_CPL : CLS_COMMIT;
    if (ft[4:3] == 2'b10)    return CLS_MSG;
    return CLS_MMIO;
  endfunction

  logic                       a_sop, b_sop;
  cls_e                       a_cls_q, b_cls_q;
  cls_e                       a_cls, b_cls;
  logic                       a_drop, b_drop;
  logic                       a_fire, b_fire;
  logic [ENT_W-1:0]           a_ent, b_ent;
  logic [NCLS-1:0]            fifo_full;
  logic [NCLS-1:0]            fifo_valid;
  logic [NCLS-1:0]            fifo_ready;
  logic [NCLS-1:0][ENT_W-1:0] fifo_data;
  logic                       a_drop_sop, b_drop_sop;
  logic [1:0]                 drop_inc;

  // The class of a SOP beat is decoded combinationally so its ready is known the same cycle.
  assign a_cls  = a_sop ? classify(rx_a_tdata[31:24]) : a_cls_q;
  assign b_cls  = b_sop ? classify(rx_b_tdata[31:24]) : b_cls_q;
  assign a_drop = ON_B[a_cls];
  assign b_drop = !ON_B[b_cls];

  assign rx_a_tready = a_drop || !fifo_full[a_cls];
  assign rx_b_tready = b_drop || !fifo_full[b_cls];
  assign a_fire      = rx_a_tvalid && rx_a_tready;
  assign b_fire      = rx_b_tvalid && rx_b_tready;

  assign a_ent = {rx_a_tlast, rx_a_tuser_vendor, rx_a_tdata, rx_a_tkeep};
  assign b_ent = {rx_b_tlast, rx_b_tuser_vendor, rx_b_tdata, rx_b_tkeep};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sop   <= 1'b1;
      b_sop   <= 1'b1;
      a_cls_q <= CLS_MMIO;
      b_cls_q <= CLS_MMIO;
    end else begin
      if (a_fire) begin
        a_sop   <= rx_a_tlast;
        a_cls_q <= a_cls;
      end
      if (b_fire) begin
        b_sop   <= rx_b_tlast;
        b_cls_q <= b_cls;
      end
    end
  end

  // Both inputs can start a misrouted packet in the same cycle.
  assign a_drop_sop = a_fire && a_drop && a_sop;
  assign b_drop_sop = b_fire && b_drop && b_sop;
  assign drop_inc   = {1'b0, a_drop_sop} + {1'b0, b_drop_sop};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt     <= '0;
      err_misroute <= 1'b0;
    end else begin
      drop_cnt     <= drop_cnt + CNT_W'(drop_inc);
      err_misroute <= err_misroute || (drop_inc != 2'd0);
    end
  end

  assign fifo_ready = {msg_tready, commit_tready, cpl_tready, mmio_tready};

  for (genvar c = 0; c < NCLS; c++) begin : g_cls
    localparam bit SRC_B = ON_B[c];

    logic             wr_en;
    logic             wr_sop;
    logic [ENT_W-1:0] wr_data;
    logic [CNT_W-1:0] cnt;

    // Each class has exactly one legal source, so its FIFO needs no arbitration.
    assign wr_en   = SRC_B ? (b_fire && !b_drop && (b_cls == 2'(c)))
                           : (a_fire && !a_drop && (a_cls == 2'(c)));
    assign wr_sop  = SRC_B ? b_sop : a_sop;
    assign wr_data = SRC_B ? b_ent : a_ent;

    pcie_rx_class_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .full     (fifo_full[c]),
      .rd_ready (fifo_ready[c]),
      .rd_valid (fifo_valid[c]),
      .rd_data  (fifo_data[c])
    );

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (wr_en && wr_sop) begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign pkt_cnt[c*CNT_W +: CNT_W] = cnt;
  end

  assign mmio_tvalid   = fifo_valid[CLS_MMIO];
  assign cpl_tvalid    = fifo_valid[CLS_CPL];
  assign commit_tvalid = fifo_valid[CLS_COMMIT];
  assign msg_tvalid    = fifo_valid[CLS_MSG];

  assign {mmio_tlast, mmio_tuser_vendor, mmio_tdata, mmio_tkeep}         = fifo_data[CLS_MMIO];
  assign {cpl_tlast, cpl_tuser_vendor, cpl_tdata, cpl_tkeep}             = fifo_data[CLS_CPL];
  assign {commit_tlast, commit_tuser_vendor, commit_tdata, commit_tkeep} = fifo_data[CLS_COMMIT];
  assign {msg_tlast, msg_tuser_vendor, msg_tdata, msg_tkeep}             = fifo_data[CLS_MSG];

endmodule

// File: tb/tb_pcie_rx_class_router.sv
// Directed bench for pcie_rx_class_router: stimulus pushes expected beats per class,
// a negedge monitor pops and compares every beat the DUT hands to a sink.
module tb_pcie_rx_class_router;

  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int UW = 10;
  localparam int CW = 32;
  localparam int EW = 1 + UW + DW + KW;
  localparam int C_MMIO = 0, C_CPL = 1, C_COMMIT = 2, C_MSG = 3;

  typedef logic [EW-1:0] ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          rx_a_tvalid, rx_a_tlast, rx_a_tready;
  logic [DW-1:0] rx_a_tdata;
  logic [KW-1:0] rx_a_tkeep;
  logic [UW-1:0] rx_a_tuser_vendor;
  logic          rx_b_tvalid, rx_b_tlast, rx_b_tready;
  logic [DW-1:0] rx_b_tdata;
  logic [KW-1:0] rx_b_tkeep;
  logic [UW-1:0] rx_b_tuser_vendor;

  logic          mmio_tvalid, mmio_tlast, mmio_tready;
  logic [DW-1:0] mmio_tdata;
  logic [KW-1:0] mmio_tkeep;
  logic [UW-1:0] mmio_tuser_vendor;
  logic          cpl_tvalid, cpl_tlast, cpl_tready;
  logic [DW-1:0] cpl_tdata;
  logic [KW-1:0] cpl_tkeep;
  logic [UW-1:0] cpl_tuser_vendor;
  logic          commit_tvalid, commit_tlast, commit_tready;
  logic [DW-1:0] commit_tdata;
  logic [KW-1:0] commit_tkeep;
  logic [UW-1:0] commit_tuser_vendor;
  logic          msg_tvalid, msg_tlast, msg_tready;
  logic [DW-1:0] msg_tdata;
  logic [KW-1:0] msg_tkeep;
  logic [UW-1:0] msg_tuser_vendor;

  logic [4*CW-1:0] pkt_cnt;
  logic [CW-1:0]   drop_cnt;
  logic            err_misroute;

  int n_cmp  = 0;
  int n_fail = 0;

  ent_t q_mmio[$];
  ent_t q_cpl[$];
  ent_t q_commit[$];
  ent_t q_msg[$];

  pcie_rx_class_router #(
    .TDATA_W(DW), .TUSER_W(UW), .CPL_ON_B(0), .COMMIT_ON_B(1), .FIFO_DEPTH(4), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_a_tvalid(rx_a_tvalid), .rx_a_tlast(rx_a_tlast), .rx_a_tdata(rx_a_tdata),
    .rx_a_tkeep(rx_a_tkeep), .rx_a_tuser_vendor(rx_a_tuser_vendor), .rx_a_tready(rx_a_tready),
    .rx_b_tvalid(rx_b_tvalid), .rx_b_tlast(rx_b_tlast), .rx_b_tdata(rx_b_tdata),
    .rx_b_tkeep(rx_b_tkeep), .rx_b_tuser_vendor(rx_b_tuser_vendor), .rx_b_tready(rx_b_tready),
    .mmio_tvalid(mmio_tvalid), .mmio_tlast(mmio_tlast), .mmio_tdata(mmio_tdata),
    .mmio_tkeep(mmio_tkeep), .mmio_tuser_vendor(mmio_tuser_vendor), .mmio_tready(mmio_tready),
    .cpl_tvalid(cpl_tvalid), .cpl_tlast(cpl_tlast), .cpl_tdata(cpl_tdata),
    .cpl_tkeep(cpl_tkeep), .cpl_tuser_vendor(cpl_tuser_vendor), .cpl_tready(cpl_tready),
    .commit_tvalid(commit_tvalid), .commit_tlast(commit_tlast), .commit_tdata(commit_tdata),
    .commit_tkeep(commit_tkeep), .commit_tuser_vendor(commit_tuser_vendor),
    .commit_tready(commit_tready),
    .msg_tvalid(msg_tvalid), .msg_tlast(msg_tlast), .msg_tdata(msg_tdata),
    .msg_tkeep(msg_tkeep), .msg_tuser_vendor(msg_tuser_vendor), .msg_tready(msg_tready),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .err_misroute(err_misroute)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input int c, input ent_t e);
    case (c)
      C_MMIO:   q_mmio.push_back(e);
      C_CPL:    q_cpl.push_back(e);
      C_COMMIT: q_commit.push_back(e);
      default:  q_msg.push_back(e);
    endcase
  endtask

  task automatic mon_class(input int c, input string tag, input logic v, input logic r,
                           input ent_t d);
    int   sz;
    ent_t e;
    if (!(v && r)) return;
    case (c)
      C_MMIO:   sz = q_mmio.size();
      C_CPL:    sz = q_cpl.size();
      C_COMMIT: sz = q_commit.size();
      default:  sz = q_msg.size();
    endcase
    check({tag, " beat expected"}, 128'(sz != 0), 128'(1));
    if (sz != 0) begin
      case (c)
        C_MMIO:   e = q_mmio.pop_front();
        C_CPL:    e = q_cpl.pop_front();
        C_COMMIT: e = q_commit.pop_front();
        default:  e = q_msg.pop_front();
      endcase
      check({tag, " beat data"}, 128'(d), 128'(e));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon_class(C_MMIO, "mmio", mmio_tvalid, mmio_tready,
                {mmio_tlast, mmio_tuser_vendor, mmio_tdata, mmio_tkeep});
      mon_class(C_CPL, "cpl", cpl_tvalid, cpl_tready,
                {cpl_tlast, cpl_tuser_vendor, cpl_tdata, cpl_tkeep});
      mon_class(C_COMMIT, "commit", commit_tvalid, commit_tready,
                {commit_tlast, commit_tuser_vendor, commit_tdata, commit_tkeep});
      mon_class(C_MSG, "msg", msg_tvalid, msg_tready,
                {msg_tlast, msg_tuser_vendor, msg_tdata, msg_tkeep});
    end
  end

  task automatic drive(input bit on_b, input logic [7:0] ft, input logic last, output ent_t e);
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    d = {$urandom(), $urandom()};
    d[31:24] = ft;
    k = KW'($urandom());
    u = UW'($urandom());
    if (on_b) begin
      rx_b_tvalid = 1'b1; rx_b_tlast = last; rx_b_tdata = d; rx_b_tkeep = k;
      rx_b_tuser_vendor = u;
    end else begin
      rx_a_tvalid = 1'b1; rx_a_tlast = last; rx_a_tdata = d; rx_a_tkeep = k;
      rx_a_tuser_vendor = u;
    end
    e = {last, u, d, k};
  endtask

  // Offers one beat until accepted; first_ready >= 0 checks ready in the first cycle.
  task automatic send_beat(input bit on_b, input int c, input bit route, input logic [7:0] ft,
                           input logic last, input int first_ready, input string tag);
    ent_t e;
    bit   ok;
    logic rdy;
    drive(on_b, ft, last, e);
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      rdy = on_b ? rx_b_tready : rx_a_tready;
      if (i == 0 && first_ready >= 0) check({tag, " ready"}, 128'(rdy), 128'(first_ready[0]));
      ok = rdy;
      @(posedge clk);
      #1;
    end
    check({tag, " accepted"}, 128'(ok), 128'(1));
    if (ok && route) sb_push(c, e);
    if (on_b) rx_b_tvalid = 1'b0;
    else      rx_a_tvalid = 1'b0;
  endtask

  // Holds a beat valid and checks that the input stays stalled for n cycles.
  task automatic hold_stall(input bit on_b, input logic [7:0] ft, input logic last, input int n,
                            input string tag);
    ent_t e;
    drive(on_b, ft, last, e);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, " stalled"}, 128'(on_b ? rx_b_tready : rx_a_tready), 128'(0));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rx_a_tvalid = 1'b0; rx_a_tlast = 1'b0; rx_a_tdata = '0; rx_a_tkeep = '0;
    rx_a_tuser_vendor = '0;
    rx_b_tvalid = 1'b0; rx_b_tlast = 1'b0; rx_b_tdata = '0; rx_b_tkeep = '0;
    rx_b_tuser_vendor = '0;
    mmio_tready = 1'b1; cpl_tready = 1'b1; commit_tready = 1'b1; msg_tready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst tvalid", 128'({msg_tvalid, commit_tvalid, cpl_tvalid, mmio_tvalid}), 128'(0));
    check("rst pkt_cnt", 128'(pkt_cnt), 128'(0));
    check("rst drop_cnt", 128'(drop_cnt), 128'(0));
    check("rst err", 128'(err_misroute), 128'(0));
    check("rst a ready", 128'(rx_a_tready), 128'(1));
    check("rst b ready", 128'(rx_b_tready), 128'(1));
    @(posedge clk);
    #1;

    // 1: single-beat MMIO write on A
    send_beat(1'b0, C_MMIO, 1'b1, 8'h60, 1'b1, 1, "t1 mmio");
    @(negedge clk);
    check("t1 mmio_tvalid", 128'(mmio_tvalid), 128'(1));
    check("t1 pkt mmio", 128'(pkt_cnt[C_MMIO*CW +: CW]), 128'(1));
    @(posedge clk);
    #1;

    // 2: CplD on A with the sink blocked fills the FIFO, then drains in order
    cpl_tready = 1'b0;
    send_beat(1'b0, C_CPL, 1'b1, 8'h4A, 1'b0, 1, "t2 b1");
    send_beat(1'b0, C_CPL, 1'b1, 8'h60, 1'b0, 1, "t2 b2");
    send_beat(1'b0, C_CPL, 1'b1, 8'h34, 1'b1, 1, "t2 b3");
    send_beat(1'b0, C_CPL, 1'b1, 8'h4A, 1'b1, 1, "t2 fill");
    hold_stall(1'b0, 8'h4A, 1'b1, 3, "t2 full");
    cpl_tready = 1'b1;
    send_beat(1'b0, C_CPL, 1'b1, 8'h4A, 1'b1, -1, "t2 resume");
    repeat (8) @(posedge clk);
    #1;
    check("t2 pkt cpl", 128'(pkt_cnt[C_CPL*CW +: CW]), 128'(3));
    check("t2 cpl drained", 128'(q_cpl.size()), 128'(0));

    // 3: blocked cpl stalls only its own beats; B commit and a later A MMIO still flow
    cpl_tready = 1'b0;
    send_beat(1'b0, C_CPL, 1'b1, 8'h4A, 1'b0, 1, "t3 c1");
    send_beat(1'b0, C_CPL, 1'b1, 8'h00, 1'b0, 1, "t3 c2");
    send_beat(1'b0, C_CPL, 1'b1, 8'h60, 1'b0, 1, "t3 c3");
    send_beat(1'b0, C_CPL, 1'b1, 8'h34, 1'b0, 1, "t3 c4");
    hold_stall(1'b0, 8'h0A, 1'b1, 2, "t3 c5");
    send_beat(1'b1, C_COMMIT, 1'b1, 8'h0A, 1'b1, 1, "t3 b commit");
    @(negedge clk);
    check("t3 a still stalled", 128'(rx_a_tready), 128'(0));
    @(posedge clk);
    #1 cpl_tready = 1'b1;
    send_beat(1'b0, C_CPL, 1'b1, 8'h0A, 1'b1, -1, "t3 c5");
    cpl_tready = 1'b0;
    send_beat(1'b0, C_CPL, 1'b1, 8'h4A, 1'b1, 1, "t3 cpl fill");
    send_beat(1'b0, C_MMIO, 1'b1, 8'h60, 1'b1, 1, "t3 mmio past full cpl");
    @(negedge clk);
    check("t3 cpl held", 128'(cpl_tvalid), 128'(1));
    check("t3 pkt commit", 128'(pkt_cnt[C_COMMIT*CW +: CW]), 128'(1));
    @(posedge clk);
    #1 cpl_tready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("t3 pkt cpl", 128'(pkt_cnt[C_CPL*CW +: CW]), 128'(5));
    check("t3 pkt mmio", 128'(pkt_cnt[C_MMIO*CW +: CW]), 128'(2));

    // 4: commit on A is a misroute
    send_beat(1'b0, C_COMMIT, 1'b0, 8'h0A, 1'b1, 1, "t4 drop");
    repeat (2) begin
      @(negedge clk);
      check("t4 no commit_tvalid", 128'(commit_tvalid), 128'(0));
    end
    check("t4 drop_cnt", 128'(drop_cnt), 128'(1));
    check("t4 err", 128'(err_misroute), 128'(1));
    check("t4 pkt commit", 128'(pkt_cnt[C_COMMIT*CW +: CW]), 128'(1));
    @(posedge clk);
    #1;

    // 5: two-beat Msg routes on A, the same packet on B is dropped
    send_beat(1'b0, C_MSG, 1'b1, 8'h34, 1'b0, 1, "t5 a b1");
    send_beat(1'b0, C_MSG, 1'b1, 8'h0A, 1'b1, 1, "t5 a b2");
    repeat (3) @(posedge clk);
    #1;
    check("t5 pkt msg", 128'(pkt_cnt[C_MSG*CW +: CW]), 128'(1));
    send_beat(1'b1, C_MSG, 1'b0, 8'h34, 1'b0, 1, "t5 b b1");
    send_beat(1'b1, C_MSG, 1'b0, 8'h0A, 1'b1, 1, "t5 b b2");
    repeat (3) @(posedge clk);
    #1;
    check("t5 drop_cnt", 128'(drop_cnt), 128'(2));
    check("t5 err sticky", 128'(err_misroute), 128'(1));
    check("t5 pkt msg after drop", 128'(pkt_cnt[C_MSG*CW +: CW]), 128'(1));
    check("t5 pkt commit after drop", 128'(pkt_cnt[C_COMMIT*CW +: CW]), 128'(1));

    // 6: reset mid-packet flushes state; next A beat is a fresh SOP
    cpl_tready = 1'b0;
    send_beat(1'b0, C_CPL, 1'b1, 8'h4A, 1'b0, 1, "t6 b1");
    rst_n = 1'b0;
    q_mmio.delete(); q_cpl.delete(); q_commit.delete(); q_msg.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("t6 cpl_tvalid", 128'(cpl_tvalid), 128'(0));
    check("t6 pkt_cnt", 128'(pkt_cnt), 128'(0));
    check("t6 drop_cnt", 128'(drop_cnt), 128'(0));
    check("t6 err", 128'(err_misroute), 128'(0));
    @(posedge clk);
    #1 cpl_tready = 1'b1;
    send_beat(1'b0, C_MMIO, 1'b1, 8'h60, 1'b1, 1, "t6 mmio sop");
    repeat (3) begin
      @(negedge clk);
      check("t6 no cpl", 128'(cpl_tvalid), 128'(0));
    end
    check("t6 pkt_cnt", 128'(pkt_cnt), 128'(1));

    repeat (10) @(posedge clk);
    #1;
    check("end q mmio", 128'(q_mmio.size()), 128'(0));
    check("end q cpl", 128'(q_cpl.size()), 128'(0));
    check("end q commit", 128'(q_commit.size()), 128'(0));
    check("end q msg", 128'(q_msg.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
